// File: rtl/bcd_serial_add_ctrl_if.sv
// Command and shared-adder signal bundle for the serial BCD add sequencer.
// slave: the sequencer; master: the command source together with the external digit adder.
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   op_a;
    logic [4*DIGITS-1:0]   op_b;
    logic                  cin;
    logic [3:0]            adder_a;
    logic [3:0]            adder_b;
    logic                  adder_cin;
    logic [3:0]            adder_sum;
    logic                  adder_cout;
    logic [4*DIGITS-1:0]   result;
    logic                  cout;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport slave (
        input  start, op_a, op_b, cin, adder_sum, adder_cout,
        output adder_a, adder_b, adder_cin, result, cout, busy, done, err
    );

    modport master (
        output start, op_a, op_b, cin, adder_sum, adder_cout,
        input  adder_a, adder_b, adder_cin, result, cout, busy, done, err
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder sequencer: steps one shared single-digit BCD adder
// through the operands LSD first, one digit per clock, then pulses done.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 3
) (
    input logic                  clk,
    input logic                  rst,
    bcd_serial_add_ctrl_if.slave bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      result_q, result_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              err_q, err_d;
    logic              ops_bcd;
    logic [3:0]        dig_a, dig_b;

    always_comb begin
        ops_bcd = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.op_a[4*i +: 4] > 4'd9 || bus.op_b[4*i +: 4] > 4'd9) ops_bcd = 1'b0;
        end
    end

    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                dig_a = a_q[4*i +: 4];
                dig_b = b_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    result_d = '0;
                    cout_d   = 1'b0;
                    if (ops_bcd) begin
                        a_d     = bus.op_a;
                        b_d     = bus.op_b;
                        carry_d = bus.cin;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        state_d = StRun;
                    end else begin
                        // Bad operand: report straight away, adder never driven.
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDXW'(i)) result_d[4*i +: 4] = bus.adder_sum;
                end
                carry_d = bus.adder_cout;
                if (idx_q == IDXW'(DIGITS - 1)) begin
                    cout_d  = bus.adder_cout;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

    assign bus.adder_a   = (state_q == StRun) ? dig_a : 4'd0;
    assign bus.adder_b   = (state_q == StRun) ? dig_b : 4'd0;
    assign bus.adder_cin = (state_q == StRun) ? carry_q : 1'b0;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: directed scenarios plus randomized operands checked
// against an integer-arithmetic model; also models the external single-digit adder.
module tb_bcd_serial_add_ctrl;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS), .IDXW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External single-digit BCD adder, combinational.
    logic [4:0] araw;
    assign araw           = 5'(bus.adder_a) + 5'(bus.adder_b) + 5'(bus.adder_cin);
    assign bus.adder_sum  = (araw > 5'd9) ? 4'(araw - 5'd10) : araw[3:0];
    assign bus.adder_cout = (araw > 5'd9);

    int total = 0;
    int bad   = 0;

    // Observations collected by launch.
    int           obs_cycles;
    int           obs_busy;
    int           tr_n;
    logic [3:0]   tr_a [8];
    logic [3:0]   tr_b [8];
    logic         tr_c [8];
    logic [W-1:0] obs_res;
    logic         obs_cout;
    logic         obs_err;
    logic         adder_nz;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd_val(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r = '0;
        int m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic bit is_bcd(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Carry entering digit i of a valid addition.
    function automatic bit carry_in(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input bit c, input int i);
        if (i == 0) return c;
        return ((bcd_val(a) % pow10(i)) + (bcd_val(b) % pow10(i)) + int'(c)) >= pow10(i);
    endfunction

    // Pulse start for one cycle, then follow the operation until done or a cycle budget.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.op_a   = W'($urandom);
        bus.op_b   = W'($urandom);
        bus.cin    = 1'($urandom);
        obs_cycles = -1;
        obs_busy   = 0;
        tr_n       = 0;
        adder_nz   = 1'b0;
        for (int k = 1; k <= DIGITS + 4; k++) begin
            @(negedge clk);
            if (bus.busy) obs_busy++;
            if (bus.adder_a != 0 || bus.adder_b != 0 || bus.adder_cin != 0) adder_nz = 1'b1;
            if (bus.busy && !bus.done && tr_n < 8) begin
                tr_a[tr_n] = bus.adder_a;
                tr_b[tr_n] = bus.adder_b;
                tr_c[tr_n] = bus.adder_cin;
                tr_n++;
            end
            if (bus.done) begin
                obs_cycles = k;
                obs_res    = bus.result;
                obs_cout   = bus.cout;
                obs_err    = bus.err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;  // rst must win over a concurrent start
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h1111;
        bus.cin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.err, bus.cout} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: busy/done/err/cout=%b want 0000",
                     {bus.busy, bus.done, bus.err, bus.cout});
        end
        total++;
        if (bus.result !== '0) begin
            bad++;
            $display("FAIL reset_result: got %h want 0", bus.result);
        end
        total++;
        if ({bus.adder_a, bus.adder_b, bus.adder_cin} !== 9'd0) begin
            bad++;
            $display("FAIL reset_adder: got %h want 0", {bus.adder_a, bus.adder_b, bus.adder_cin});
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int           s;
        logic [W-1:0] er;
        logic [W-1:0] held;
        s  = bcd_val(a) + bcd_val(b) + int'(c);
        er = to_bcd(s % pow10(DIGITS));
        launch(a, b, c);
        total++;
        if (obs_cycles != DIGITS + 1 || obs_busy != DIGITS + 1) begin
            bad++;
            $display("FAIL add_timing %h+%h: done cycle %0d busy %0d want %0d", a, b,
                     obs_cycles, obs_busy, DIGITS + 1);
        end
        total++;
        if ({obs_res, obs_cout, obs_err} !== {er, s >= pow10(DIGITS), 1'b0}) begin
            bad++;
            $display("FAIL add_result %h+%h+%0d: got %h c%0d e%0d want %h c%0d e0", a, b, c,
                     obs_res, obs_cout, obs_err, er, s >= pow10(DIGITS));
        end
        for (int i = 0; i < DIGITS; i++) begin
            total++;
            if (i >= tr_n || tr_a[i] !== a[4*i +: 4] || tr_b[i] !== b[4*i +: 4] ||
                tr_c[i] !== carry_in(a, b, c, i)) begin
                bad++;
                $display("FAIL add_drive digit %0d: got a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                         i, tr_a[i], tr_b[i], tr_c[i], a[4*i +: 4], b[4*i +: 4],
                         carry_in(a, b, c, i));
            end
        end
        held = obs_res;
        @(negedge clk);
        total++;
        if ({bus.done, bus.busy} !== 2'b00 || bus.result !== held) begin
            bad++;
            $display("FAIL add_after_done: done=%b busy=%b result=%h want 0 0 %h",
                     bus.done, bus.busy, bus.result, held);
        end
    endtask

    task automatic test_error();
        launch(16'h12A4, 16'h0000, 1'b0);
        total++;
        if (obs_cycles != 1) begin
            bad++;
            $display("FAIL err_timing: done cycle %0d want 1", obs_cycles);
        end
        total++;
        if ({obs_err, obs_cout, obs_res} !== {1'b1, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL err_outputs: err=%b cout=%b result=%h want 1 0 0000",
                     obs_err, obs_cout, obs_res);
        end
        total++;
        if (adder_nz !== 1'b0) begin
            bad++;
            $display("FAIL err_adder_idle: adder driven nonzero=%b want 0", adder_nz);
        end
        launch(16'h0005, 16'h0004, 1'b0);
        total++;
        if ({obs_err, obs_res} !== {1'b0, 16'h0009}) begin
            bad++;
            $display("FAIL err_recover: err=%b result=%h want 0 0009", obs_err, obs_res);
        end
    endtask

    task automatic test_back_to_back();
        int seen = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 16'h0008;
        bus.op_b  = 16'h0007;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= DIGITS + 4; k++) begin
            @(negedge clk);
            if (k == 2) begin
                bus.start = 1'b1;
                bus.op_a  = 16'h1111;
                bus.op_b  = 16'h1111;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                seen = k;
                obs_res = bus.result;
                break;
            end
        end
        total++;
        if (seen != DIGITS + 1 || obs_res !== 16'h0015) begin
            bad++;
            $display("FAIL busy_start_ignored: done cycle %0d result %h want %0d 0015",
                     seen, obs_res, DIGITS + 1);
        end
        // launch waits one negedge, so its start lands in the first IDLE cycle.
        launch(16'h0123, 16'h0456, 1'b1);
        total++;
        if (obs_cycles != DIGITS + 1 || obs_res !== 16'h0580) begin
            bad++;
            $display("FAIL first_idle_start: done cycle %0d result %h want %0d 0580",
                     obs_cycles, obs_res, DIGITS + 1);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 16'h4321;
        bus.op_b  = 16'h1111;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.err, bus.cout, bus.result, bus.adder_a, bus.adder_b,
             bus.adder_cin} !== '0) begin
            bad++;
            $display("FAIL abort_clear: busy=%b done=%b err=%b cout=%b result=%h adder=%h%h%b",
                     bus.busy, bus.done, bus.err, bus.cout, bus.result, bus.adder_a,
                     bus.adder_b, bus.adder_cin);
        end
        repeat (DIGITS + 2) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: activity after abort=%b want 0", saw_done);
        end
        launch(16'h4321, 16'h1111, 1'b0);
        total++;
        if (obs_cycles != DIGITS + 1 || obs_res !== 16'h5432) begin
            bad++;
            $display("FAIL abort_restart: done cycle %0d result %h want %0d 5432",
                     obs_cycles, obs_res, DIGITS + 1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a, b, er;
            logic         c;
            bit           ok;
            int           s;
            for (int i = 0; i < DIGITS; i++) begin
                a[4*i +: 4] = 4'($urandom_range(0, 9));
                b[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 5) == 0) a[4*$urandom_range(0, DIGITS-1) +: 4] =
                4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) b[4*$urandom_range(0, DIGITS-1) +: 4] =
                4'($urandom_range(10, 15));
            c  = 1'($urandom);
            ok = is_bcd(a) && is_bcd(b);
            s  = bcd_val(a) + bcd_val(b) + int'(c);
            er = ok ? to_bcd(s % pow10(DIGITS)) : '0;
            launch(a, b, c);
            total++;
            if (obs_cycles != (ok ? DIGITS + 1 : 1) ||
                {obs_res, obs_cout, obs_err} !== {er, ok && s >= pow10(DIGITS), !ok}) begin
                bad++;
                $display("FAIL random %h+%h+%0d: cyc %0d res %h c%0d e%0d want cyc %0d %h c%0d e%0d",
                         a, b, c, obs_cycles, obs_res, obs_cout, obs_err,
                         ok ? DIGITS + 1 : 1, er, ok && s >= pow10(DIGITS), !ok);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;
        test_reset();
        test_add(16'h1234, 16'h5678, 1'b0);
        test_add(16'h9999, 16'h0001, 1'b0);
        test_add(16'h9999, 16'h9999, 1'b1);
        test_error();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
